// File: rtl/lcd_pattern_pkg.sv
`default_nettype none
// ============================================================================
// lcd_pattern_pkg
// Palette colours, pattern-mode encodings and the RGB888 -> RGB565 helper.
// Rev 1.0
// ============================================================================
package lcd_pattern_pkg;

   typedef enum logic [2:0] {
      MODE_VBARS   = 3'd0,
      MODE_HBARS   = 3'd1,
      MODE_CHECKER = 3'd2,
      MODE_GREY    = 3'd3,
      MODE_ROTATE  = 3'd4,
      MODE_SOLID   = 3'd5
   } mode_t;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_H    = 2'd1,
      DIV_V    = 2'd2
   } div_state_t;

   localparam logic [23:0] PAL_WHITE   = 24'hFFFFFF;
   localparam logic [23:0] PAL_BLACK   = 24'h000000;
   localparam logic [23:0] PAL_RED     = 24'hFF0000;
   localparam logic [23:0] PAL_GREEN   = 24'h00FF00;
   localparam logic [23:0] PAL_BLUE    = 24'h0000FF;
   localparam logic [23:0] PAL_YELLOW  = 24'hFFFF00;
   localparam logic [23:0] PAL_CYAN    = 24'h00FFFF;
   localparam logic [23:0] PAL_MAGENTA = 24'hFF00FF;

   function automatic logic [23:0] pal_color(input logic [2:0] idx);
      case (idx)
         3'd0:    return PAL_WHITE;
         3'd1:    return PAL_BLACK;
         3'd2:    return PAL_RED;
         3'd3:    return PAL_GREEN;
         3'd4:    return PAL_BLUE;
         3'd5:    return PAL_YELLOW;
         3'd6:    return PAL_CYAN;
         default: return PAL_MAGENTA;
      endcase
   endfunction

   function automatic logic [15:0] rgb888_to_565(input logic [23:0] c);
      return {c[23:19], c[15:10], c[7:3]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_div_seq.sv
`default_nettype none
// ============================================================================
// lcd_div_seq
// Restoring divider: one load cycle then W iterations, one quotient bit each.
// Rev 1.0
// ============================================================================
module lcd_div_seq #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient
);
   localparam int CW = $clog2(W + 1);

   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_rem;
   logic [W-1:0]  r_quo;
   logic [W:0]    w_shift;
   logic [W:0]    w_trial;

   // Dividend bits shift out of r_quo's MSB while quotient bits enter its LSB.
   assign w_shift  = {r_rem, r_quo[W-1]};
   assign w_trial  = w_shift - {1'b0, divisor};
   assign quotient = r_quo;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_rem <= '0;
         r_quo <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            r_rem <= '0;
            r_quo <= dividend;
            r_cnt <= CW'(W);
            busy  <= 1'b1;
         end else if (busy) begin
            if (!w_trial[W]) begin
               r_rem <= w_trial[W-1:0];
               r_quo <= {r_quo[W-2:0], 1'b1};
            end else begin
               r_rem <= w_shift[W-1:0];
               r_quo <= {r_quo[W-2:0], 1'b0};
            end
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/lcd_pattern_gen.sv
`default_nettype none
// ============================================================================
// lcd_pattern_gen
// Per-frame selectable LCD test patterns with bar sizes divided out in blanking.
// Rev 1.0
// ============================================================================
module lcd_pattern_gen
   import lcd_pattern_pkg::*;
#(
   parameter int NUM_BARS    = 8,
   parameter int XW          = 11,
   parameter int PIX_W       = 24,
   parameter int CHECK_SHIFT = 5,
   parameter int ROT_FRAMES  = 30
) (
   input  logic             lcd_pclk,
   input  logic             rst,
   input  logic             de,
   input  logic             frame_sync,
   input  logic [XW-1:0]    pixel_xpos,
   input  logic [XW-1:0]    pixel_ypos,
   input  logic [XW-1:0]    h_disp,
   input  logic [XW-1:0]    v_disp,
   input  logic [2:0]       mode,
   input  logic [23:0]      solid_rgb,
   output logic [PIX_W-1:0] pixel_data,
   output logic             cfg_valid
);
   localparam int            BW       = 5;
   localparam logic [BW-1:0] LAST_BAR = BW'(NUM_BARS - 1);
   localparam logic [BW-1:0] N_BARS   = BW'(NUM_BARS);
   localparam int            FCW      = $clog2(ROT_FRAMES + 1);
   localparam logic [FCW-1:0] LAST_FR = FCW'(ROT_FRAMES - 1);

   mode_t            r_mode;
   logic [XW-1:0]    r_h, r_v, r_bw_tmp, r_bar_w, r_bar_h;
   logic [23:0]      r_solid;
   logic             r_cfg_valid;
   logic [FCW-1:0]   r_fcnt;
   logic [BW-1:0]    r_rot;
   div_state_t       r_state, w_state_nxt;
   logic             w_div_start, w_cap_w, w_commit;
   logic [XW-1:0]    w_div_dividend, w_div_q;
   logic             w_div_busy, w_div_done;

   function automatic logic [BW-1:0] bar_inc(input logic [BW-1:0] b);
      return (b == LAST_BAR) ? b : b + BW'(1);
   endfunction

   lcd_div_seq #(.W(XW)) u_div (
      .clk      (lcd_pclk),
      .rst      (rst),
      .start    (w_div_start),
      .dividend (w_div_dividend),
      .divisor  (XW'(NUM_BARS)),
      .busy     (w_div_busy),
      .done     (w_div_done),
      .quotient (w_div_q)
   );

   // frame_sync always restarts from DIV_H using the live h_disp it latches.
   always_comb begin
      w_state_nxt    = r_state;
      w_div_start    = 1'b0;
      w_div_dividend = r_v;
      w_cap_w        = 1'b0;
      w_commit       = 1'b0;
      if (frame_sync) begin
         w_state_nxt    = DIV_H;
         w_div_start    = 1'b1;
         w_div_dividend = h_disp;
      end else begin
         case (r_state)
            DIV_H: if (w_div_done) begin
               w_state_nxt = DIV_V;
               w_div_start = 1'b1;
               w_cap_w     = 1'b1;
            end
            DIV_V: if (w_div_done) begin
               w_state_nxt = DIV_IDLE;
               w_commit    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge lcd_pclk or posedge rst) begin
      if (rst) begin
         r_state     <= DIV_IDLE;
         r_mode      <= MODE_VBARS;
         r_h         <= '0;
         r_v         <= '0;
         r_solid     <= '0;
         r_bw_tmp    <= '0;
         r_bar_w     <= '0;
         r_bar_h     <= '0;
         r_cfg_valid <= 1'b0;
         r_fcnt      <= '0;
         r_rot       <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (frame_sync) begin
            r_mode  <= (mode > 3'd5) ? MODE_VBARS : mode_t'(mode);
            r_h     <= h_disp;
            r_v     <= v_disp;
            r_solid <= solid_rgb;
            if (r_fcnt == LAST_FR) begin
               r_fcnt <= '0;
               r_rot  <= (r_rot == LAST_BAR) ? '0 : r_rot + BW'(1);
            end else begin
               r_fcnt <= r_fcnt + FCW'(1);
            end
         end
         if (w_cap_w) r_bw_tmp <= w_div_q;
         if (w_commit) begin
            r_bar_w     <= r_bw_tmp;
            r_bar_h     <= w_div_q;
            r_cfg_valid <= 1'b1;
         end
      end
   end

   // Incremental bar tracking: r_xcnt/r_xbar describe the next column,
   // r_ycnt/r_ybar describe the row currently being drawn.
   logic [XW-1:0] r_xcnt, r_ycnt, w_xcnt_cur, w_xcnt_inc, w_ycnt_inc, w_ycnt_row;
   logic [BW-1:0] r_xbar, r_ybar, w_xbar_cur, w_ybar_row, w_vbar, w_hbar;
   logic          w_xfirst, w_line_start, w_yadv;

   assign w_xfirst     = (pixel_xpos == '0);
   assign w_xcnt_cur   = w_xfirst ? '0 : r_xcnt;
   assign w_xbar_cur   = w_xfirst ? '0 : r_xbar;
   assign w_xcnt_inc   = w_xcnt_cur + XW'(1);
   assign w_vbar       = (r_bar_w == '0) ? '0 : w_xbar_cur;
   assign w_line_start = de && w_xfirst;
   assign w_ycnt_inc   = r_ycnt + XW'(1);
   assign w_yadv       = (w_ycnt_inc == r_bar_h);
   assign w_ycnt_row   = (pixel_ypos == '0) ? '0 : (w_yadv ? '0 : w_ycnt_inc);
   assign w_ybar_row   = (pixel_ypos == '0) ? '0 : (w_yadv ? bar_inc(r_ybar) : r_ybar);
   assign w_hbar       = (r_bar_h == '0) ? '0 : (w_line_start ? w_ybar_row : r_ybar);

   always_ff @(posedge lcd_pclk or posedge rst) begin
      if (rst) begin
         r_xcnt <= '0;
         r_xbar <= '0;
         r_ycnt <= '0;
         r_ybar <= '0;
      end else begin
         if (de) begin
            if (w_xcnt_inc == r_bar_w) begin
               r_xcnt <= '0;
               r_xbar <= bar_inc(w_xbar_cur);
            end else begin
               r_xcnt <= w_xcnt_inc;
               r_xbar <= w_xbar_cur;
            end
         end
         if (w_line_start) begin
            r_ycnt <= w_ycnt_row;
            r_ybar <= w_ybar_row;
         end
      end
   end

   logic [BW-1:0]    w_rot_sum, w_rot_idx;
   logic [23:0]      w_color;
   logic [PIX_W-1:0] w_pix;

   assign w_rot_sum = w_vbar + r_rot;
   assign w_rot_idx = (w_rot_sum >= N_BARS) ? w_rot_sum - N_BARS : w_rot_sum;

   always_comb begin
      w_color = PAL_BLACK;
      case (r_mode)
         MODE_HBARS:   w_color = pal_color(w_hbar[2:0]);
         MODE_CHECKER: w_color = (pixel_xpos[CHECK_SHIFT] ^ pixel_ypos[CHECK_SHIFT]) ?
                                 PAL_WHITE : PAL_BLACK;
         MODE_GREY:    w_color = {3{pixel_xpos[7:0]}};
         MODE_ROTATE:  w_color = pal_color(w_rot_idx[2:0]);
         MODE_SOLID:   w_color = r_solid;
         default:      w_color = pal_color(w_vbar[2:0]);
      endcase
      if (!de || !r_cfg_valid) w_color = PAL_BLACK;
   end

   generate
      if (PIX_W == 16) begin : g_rgb565
         assign w_pix = rgb888_to_565(w_color);
      end else begin : g_rgb888
         assign w_pix = w_color[PIX_W-1:0];
      end
   endgenerate

   always_ff @(posedge lcd_pclk or posedge rst) begin
      if (rst) pixel_data <= '0;
      else     pixel_data <= w_pix;
   end

   assign cfg_valid = r_cfg_valid;

   a_no_sync_in_active: assert property (@(posedge lcd_pclk) disable iff (rst)
      !(frame_sync && de));
   a_idle_not_busy: assert property (@(posedge lcd_pclk) disable iff (rst)
      (r_state == DIV_IDLE) |-> !w_div_busy);

endmodule
`default_nettype wire

// File: tb/tb_lcd_pattern_gen.sv
`default_nettype none
// ============================================================================
// tb_lcd_pattern_gen
// Random-stimulus bench with an arithmetic reference model; RGB888 and RGB565 DUTs.
// Rev 1.0
// ============================================================================
module tb_lcd_pattern_gen;
   localparam int XW = 11;
   localparam int NB = 5;
   localparam int RF = 2;
   localparam int CS = 5;
   localparam int DIV_LAT = 2 * XW + 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          de = 1'b0;
   logic          frame_sync = 1'b0;
   logic [XW-1:0] xpos = '0, ypos = '0, h_disp = '0, v_disp = '0;
   logic [2:0]    mode = '0;
   logic [23:0]   solid_rgb = '0;
   logic [23:0]   pix24;
   logic [15:0]   pix16;
   logic          cfg24, cfg16;

   always #5 clk = ~clk;

   lcd_pattern_gen #(.NUM_BARS(NB), .XW(XW), .PIX_W(24), .CHECK_SHIFT(CS), .ROT_FRAMES(RF)) dut (
      .lcd_pclk(clk), .rst(rst), .de(de), .frame_sync(frame_sync),
      .pixel_xpos(xpos), .pixel_ypos(ypos), .h_disp(h_disp), .v_disp(v_disp),
      .mode(mode), .solid_rgb(solid_rgb), .pixel_data(pix24), .cfg_valid(cfg24));

   lcd_pattern_gen #(.NUM_BARS(NB), .XW(XW), .PIX_W(16), .CHECK_SHIFT(CS), .ROT_FRAMES(RF)) dut16 (
      .lcd_pclk(clk), .rst(rst), .de(de), .frame_sync(frame_sync),
      .pixel_xpos(xpos), .pixel_ypos(ypos), .h_disp(h_disp), .v_disp(v_disp),
      .mode(mode), .solid_rgb(solid_rgb), .pixel_data(pix16), .cfg_valid(cfg16));

   int n_checks = 0;
   int n_errors = 0;
   int cur_x = 0, cur_y = 0;

   // reference model state
   int          m_mode = 0, m_h = 0, m_v = 0, m_bw = 0, m_bh = 0;
   int          m_pbw = 0, m_pbh = 0, m_cd = 0, m_frames = 0;
   bit          m_cfg = 1'b0;
   logic [23:0] m_solid = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at x=%0d y=%0d frame=%0d: got %0h expected %0h",
                  tag, cur_x, cur_y, m_frames, got, exp);
      end
   endtask

   function automatic logic [23:0] pal(input int i);
      case (i % 8)
         0: return 24'hFFFFFF;
         1: return 24'h000000;
         2: return 24'hFF0000;
         3: return 24'h00FF00;
         4: return 24'h0000FF;
         5: return 24'hFFFF00;
         6: return 24'h00FFFF;
         default: return 24'hFF00FF;
      endcase
   endfunction

   function automatic int bar_of(input int p, input int size);
      if (size == 0) return 0;
      return (p / size > NB - 1) ? NB - 1 : p / size;
   endfunction

   function automatic logic [23:0] model_color(input bit d, input int x, input int y);
      int g;
      if (!d || !m_cfg) return 24'h0;
      case (m_mode)
         1: return pal(bar_of(y, m_bh));
         2: return ((((x >> CS) ^ (y >> CS)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
         3: begin g = x % 256; return 24'(g * 65536 + g * 256 + g); end
         4: return pal((bar_of(x, m_bw) + (m_frames / RF) % NB) % NB);
         5: return m_solid;
         default: return pal(bar_of(x, m_bw));
      endcase
   endfunction

   function automatic logic [15:0] to565(input logic [23:0] c);
      int r, g, b;
      r = (int'(c) / 65536) / 8;
      g = ((int'(c) / 256) % 256) / 4;
      b = (int'(c) % 256) / 8;
      return 16'(r * 2048 + g * 32 + b);
   endfunction

   // One pixel clock: drive, advance model at the edge, check on the falling edge.
   task automatic step(input bit d, input int x, input int y, input bit fs);
      logic [23:0] e;
      de = d; xpos = XW'(x); ypos = XW'(y); frame_sync = fs;
      cur_x = x; cur_y = y;
      if (!fs) begin
         h_disp    = XW'($urandom);
         v_disp    = XW'($urandom);
         mode      = 3'($urandom);
         solid_rgb = 24'($urandom);
      end
      e = model_color(d, x, y);
      @(posedge clk);
      if (fs && !rst) begin
         m_mode   = (int'(mode) > 5) ? 0 : int'(mode);
         m_h      = int'(h_disp);
         m_v      = int'(v_disp);
         m_solid  = solid_rgb;
         m_pbw    = m_h / NB;
         m_pbh    = m_v / NB;
         m_cd     = DIV_LAT;
         m_frames = m_frames + 1;
      end else if (m_cd > 0 && !rst) begin
         m_cd = m_cd - 1;
         if (m_cd == 0) begin
            m_bw  = m_pbw;
            m_bh  = m_pbh;
            m_cfg = 1'b1;
         end
      end
      @(negedge clk);
      check("pix888", pix24, e);
      check("pix565", pix16, to565(e));
      check("cfg_valid", cfg24, m_cfg);
      check("cfg_valid16", cfg16, m_cfg);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #1;
      check("rst_pix888", pix24, 0);
      check("rst_pix565", pix16, 0);
      check("rst_cfg", cfg24, 0);
      m_mode = 0; m_h = 0; m_v = 0; m_bw = 0; m_bh = 0;
      m_pbw = 0; m_pbh = 0; m_cd = 0; m_frames = 0; m_cfg = 1'b0; m_solid = '0;
      repeat (2) step(1'b0, 0, 0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic sync(input int h, input int v, input int md, input logic [23:0] sc);
      h_disp = XW'(h); v_disp = XW'(v); mode = 3'(md); solid_rgb = sc;
      step(1'b0, 0, 0, 1'b1);
   endtask

   task automatic blank(input int n);
      for (int i = 0; i < n; i++) step(1'b0, $urandom_range(0, 2047), $urandom_range(0, 2047), 1'b0);
   endtask

   task automatic frame(input int h, input int v, input int md, input logic [23:0] sc);
      sync(h, v, md, sc);
      blank(DIV_LAT + 4);
      for (int y = 0; y < v; y++) begin
         for (int x = 0; x < h; x++) step(1'b1, x, y, 1'b0);
         blank(1);
      end
   endtask

   initial begin
      @(negedge clk);
      apply_reset();
      // first frame after reset stays black
      for (int x = 0; x < 20; x++) step(1'b1, x, 0, 1'b0);
      blank(2);
      frame(800, 5, 0, 24'h0);
      // reset in the middle of a division
      h_disp = XW'(500);
      sync(500, 20, 1, 24'h0);
      blank(8);
      apply_reset();
      frame(803, 3, 0, 24'h0);
      // reset in the middle of an active line
      sync(100, 10, 0, 24'h0);
      blank(DIV_LAT + 4);
      for (int x = 0; x < 50; x++) step(1'b1, x, 0, 1'b0);
      apply_reset();
      frame(3, 3, 0, 24'h0);
      frame(3, 3, 1, 24'h0);
      // frame_sync while the divider is busy
      sync(400, 30, 0, 24'h0);
      blank(6);
      frame(600, 2, 0, 24'h0);
      frame(70, 40, 2, 24'h0);
      frame(20, 40, 1, 24'h0);
      frame(300, 2, 3, 24'h0);
      frame(40, 3, 5, 24'h12F8C4);
      frame(30, 3, 7, 24'h0);
      for (int f = 0; f < 12; f++) frame(25, 3, 4, 24'h0);
      for (int f = 0; f < 15; f++)
         frame($urandom_range(1, 130), $urandom_range(1, 12), $urandom_range(0, 7), 24'($urandom));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
